// File: rtl/rggen_access_arbiter_pkg.sv
// Shared definitions for the register access arbiter.
// Holds the arbiter state encoding, the response status codes and a helper
// that sizes requester index fields (at least one bit, even when N == 1).
package rggen_access_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        RESPOND  = 2'd3
    } arbiter_state_e;

    localparam logic [1:0] STATUS_OKAY         = 2'b00;
    localparam logic [1:0] STATUS_EXOKAY       = 2'b01;
    localparam logic [1:0] STATUS_SLAVE_ERROR  = 2'b10;
    localparam logic [1:0] STATUS_DECODE_ERROR = 2'b11;

    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rggen_round_robin_selector.sv
// Combinational round-robin selector.
// Picks the first asserted request at or above i_pointer, wrapping around.
//   i_request      N      request vector
//   i_pointer      IDX_W  highest-priority index (must be < N)
//   o_grant        N      one-hot grant (all zero when nothing requests)
//   o_grant_index  IDX_W  index of the granted request
module rggen_round_robin_selector
    import rggen_access_arbiter_pkg::*;
#(
    parameter  int N     = 2,
    localparam int IDX_W = index_width(N)
)(
    input  logic [N-1:0]     i_request,
    input  logic [IDX_W-1:0] i_pointer,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_grant_index
);

    int unsigned      w_pos;
    logic [IDX_W-1:0] w_pos_idx;
    logic             w_found;

    always_comb begin
        o_grant       = '0;
        o_grant_index = '0;
        w_found       = 1'b0;
        w_pos         = 0;
        w_pos_idx     = '0;
        for (int unsigned off = 0; off < N; off++) begin
            // pointer + off, folded back into 0..N-1
            w_pos = 32'(i_pointer) + off;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            w_pos_idx = IDX_W'(w_pos);
            if (!w_found && i_request[w_pos_idx]) begin
                w_found            = 1'b1;
                o_grant[w_pos_idx] = 1'b1;
                o_grant_index      = w_pos_idx;
            end
        end
    end

endmodule

// File: rtl/rggen_register_access_arbiter.sv
// Register access arbiter: shares one register-block access channel between
// N hosts, with exactly one access outstanding at a time.
//   i_clk / i_rst_n           clock, asynchronous active-low reset
//   i_req_* / o_req_ready     per-requester request channel (packed slices)
//   o_rsp_valid / i_rsp_ready per-requester response handshake
//   o_rsp_status / o_rsp_data captured response, shared by all requesters
//   o_access_* / i_access_ready  downstream request channel
//   i_response_*              downstream single-cycle response
module rggen_register_access_arbiter
    import rggen_access_arbiter_pkg::*;
#(
    parameter int N             = 2,
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32
)(
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [N-1:0]              i_req_valid,
    output logic [N-1:0]              o_req_ready,
    input  logic [N-1:0]              i_req_write,
    input  logic [N*ADDRESS_WIDTH-1:0] i_req_address,
    input  logic [N*DATA_WIDTH-1:0]   i_req_data,
    input  logic [N*DATA_WIDTH-1:0]   i_req_strobe,
    output logic [N-1:0]              o_rsp_valid,
    input  logic [N-1:0]              i_rsp_ready,
    output logic [1:0]                o_rsp_status,
    output logic [DATA_WIDTH-1:0]     o_rsp_data,
    output logic                      o_access_valid,
    input  logic                      i_access_ready,
    output logic                      o_access_write,
    output logic [ADDRESS_WIDTH-1:0]  o_access_address,
    output logic [DATA_WIDTH-1:0]     o_access_data,
    output logic [DATA_WIDTH-1:0]     o_access_strobe,
    input  logic                      i_response_valid,
    input  logic [1:0]                i_response_status,
    input  logic [DATA_WIDTH-1:0]     i_response_data
);

    localparam int IDX_W = index_width(N);

    arbiter_state_e          r_state;
    arbiter_state_e          w_next_state;
    logic [IDX_W-1:0]        r_pointer;
    logic [IDX_W-1:0]        r_owner;
    logic                    r_write;
    logic [ADDRESS_WIDTH-1:0] r_address;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [DATA_WIDTH-1:0]   r_strobe;
    logic [1:0]              r_status;
    logic [DATA_WIDTH-1:0]   r_rsp_data;

    logic [N-1:0]            w_grant;
    logic [IDX_W-1:0]        w_grant_index;
    logic                    w_accept;
    logic                    w_capture;

    rggen_round_robin_selector #(
        .N (N)
    ) u_selector (
        .i_request     (i_req_valid),
        .i_pointer     (r_pointer),
        .o_grant       (w_grant),
        .o_grant_index (w_grant_index)
    );

    always_comb begin
        w_next_state   = r_state;
        o_req_ready    = '0;
        o_rsp_valid    = '0;
        o_access_valid = 1'b0;
        w_accept       = 1'b0;
        w_capture      = 1'b0;
        case (r_state)
            IDLE: begin
                o_req_ready = w_grant;
                if (|(i_req_valid & w_grant)) begin
                    w_accept     = 1'b1;
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                o_access_valid = 1'b1;
                if (i_access_ready) begin
                    // a response arriving with the accept skips WAIT_RSP
                    if (i_response_valid) begin
                        w_capture    = 1'b1;
                        w_next_state = RESPOND;
                    end else begin
                        w_next_state = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                if (i_response_valid) begin
                    w_capture    = 1'b1;
                    w_next_state = RESPOND;
                end
            end
            RESPOND: begin
                o_rsp_valid[r_owner] = 1'b1;
                if (i_rsp_ready[r_owner]) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pointer  <= '0;
            r_owner    <= '0;
            r_write    <= 1'b0;
            r_address  <= '0;
            r_data     <= '0;
            r_strobe   <= '0;
            r_status   <= STATUS_OKAY;
            r_rsp_data <= '0;
        end else begin
            if (w_accept) begin
                r_owner   <= w_grant_index;
                r_pointer <= (w_grant_index == IDX_W'(N - 1)) ? '0 : w_grant_index + 1'b1;
                r_write   <= i_req_write[w_grant_index];
                r_address <= i_req_address[w_grant_index*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                r_data    <= i_req_data[w_grant_index*DATA_WIDTH +: DATA_WIDTH];
                r_strobe  <= i_req_strobe[w_grant_index*DATA_WIDTH +: DATA_WIDTH];
            end
            if (w_capture) begin
                r_status   <= i_response_status;
                r_rsp_data <= i_response_data;
            end
        end
    end

    assign o_access_write   = r_write;
    assign o_access_address = r_address;
    assign o_access_data    = r_data;
    assign o_access_strobe  = r_strobe;
    assign o_rsp_status     = r_status;
    assign o_rsp_data       = r_rsp_data;

endmodule
